// File: rtl/kv_cache_writer_if.sv
// rtl/kv_cache_writer_if.sv - K/V row input streams and K/V BRAM write ports
interface kv_cache_writer_if #(
  parameter int M = 166,
  parameter int N = 44
);
  localparam int AW = $clog2(M);

  logic            k_in_valid;
  logic            k_in_ready;
  logic [N*16-1:0] k_in_data;
  logic            v_in_valid;
  logic            v_in_ready;
  logic [N*16-1:0] v_in_data;

  logic            K_ram_we;
  logic [AW-1:0]   K_ram_waddr;
  logic [N*8-1:0]  K_ram_wdata;
  logic            V_ram_we;
  logic [AW-1:0]   V_ram_waddr;
  logic [N*8-1:0]  V_ram_wdata;

  // Projection-stage side: drives rows, observes readies and the BRAM port
  modport master (
    output k_in_valid, k_in_data, v_in_valid, v_in_data,
    input  k_in_ready, v_in_ready,
    input  K_ram_we, K_ram_waddr, K_ram_wdata,
    input  V_ram_we, V_ram_waddr, V_ram_wdata
  );

  // Writer side: consumes rows and drives the BRAM write ports
  modport slave (
    input  k_in_valid, k_in_data, v_in_valid, v_in_data,
    output k_in_ready, v_in_ready,
    output K_ram_we, K_ram_waddr, K_ram_wdata,
    output V_ram_we, V_ram_waddr, V_ram_wdata
  );
endinterface

// File: rtl/kv_cache_writer.sv
// rtl/kv_cache_writer.sv - requantises K/V int16 rows to int8 and fills the K/V row BRAMs
module kv_cache_writer #(
  parameter int M = 166,
  parameter int N = 44
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   freeze,
  input  logic [3:0]             shift,
  kv_cache_writer_if.slave       bus,
  output logic [$clog2(M+1)-1:0] rows_valid,
  output logic                   kv_full,
  output logic                   kv_done
);

  localparam int AW = $clog2(M);
  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] M_C = CW'(M);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]  k_ptr_q, k_ptr_d, v_ptr_q, v_ptr_d;
  logic [CW-1:0]  k_cnt_q, k_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0]  rows_valid_q, rows_valid_d;
  logic           kv_full_q, kv_full_d;
  logic           kv_done_q, kv_done_d;

  logic           k_we_q, k_we_d, v_we_q, v_we_d;
  logic [AW-1:0]  k_waddr_q, k_waddr_d, v_waddr_q, v_waddr_d;
  logic [N*8-1:0] k_wdata_q, k_wdata_d, v_wdata_q, v_wdata_d;

  logic           k_ready, v_ready, k_acc, v_acc, both_full;
  logic [N*8-1:0] k_row, v_row;

  // Round-half-up arithmetic shift in 17 bits, then saturate to int8
  function automatic logic [7:0] requant(input logic [15:0] x, input logic [3:0] sh);
    logic signed [16:0] xe;
    logic signed [16:0] rnd;
    logic signed [16:0] t;
    xe  = {x[15], x};
    rnd = (sh == 4'd0) ? 17'sd0 : (17'sd1 <<< (sh - 4'd1));
    t   = (xe + rnd) >>> sh;
    if (t > 17'sd127) begin
      return 8'h7F;
    end else if (t < -17'sd128) begin
      return 8'h80;
    end else begin
      return t[7:0];
    end
  endfunction

  // A stream stops taking rows while frozen, while clearing, or once its buffer is full
  assign k_ready = !freeze && !clear && (k_ptr_q != M_C);
  assign v_ready = !freeze && !clear && (v_ptr_q != M_C);
  assign k_acc   = bus.k_in_valid && k_ready;
  assign v_acc   = bus.v_in_valid && v_ready;
  assign both_full = (k_cnt_q == M_C) && (v_cnt_q == M_C);

  assign bus.k_in_ready  = k_ready;
  assign bus.v_in_ready  = v_ready;
  assign bus.K_ram_we    = k_we_q;
  assign bus.K_ram_waddr = k_waddr_q;
  assign bus.K_ram_wdata = k_wdata_q;
  assign bus.V_ram_we    = v_we_q;
  assign bus.V_ram_waddr = v_waddr_q;
  assign bus.V_ram_wdata = v_wdata_q;
  assign rows_valid      = rows_valid_q;
  assign kv_full         = kv_full_q;
  assign kv_done         = kv_done_q;

  // Lane-wise requantisation of the incoming K and V rows
  always_comb begin
    k_row = '0;
    v_row = '0;
    for (int i = 0; i < N; i++) begin
      k_row[i*8 +: 8] = requant(bus.k_in_data[i*16 +: 16], shift);
      v_row[i*8 +: 8] = requant(bus.v_in_data[i*16 +: 16], shift);
    end
  end

  // Pointers, write-port staging and counters; a row is counted only after its write is presented
  always_comb begin
    k_ptr_d   = k_ptr_q;
    v_ptr_d   = v_ptr_q;
    k_we_d    = k_acc;
    v_we_d    = v_acc;
    k_waddr_d = k_waddr_q;
    v_waddr_d = v_waddr_q;
    k_wdata_d = k_wdata_q;
    v_wdata_d = v_wdata_q;
    k_cnt_d   = k_cnt_q + (k_we_q ? CW'(1) : CW'(0));
    v_cnt_d   = v_cnt_q + (v_we_q ? CW'(1) : CW'(0));
    rows_valid_d = (k_cnt_q < v_cnt_q) ? k_cnt_q : v_cnt_q;
    if (k_acc) begin
      k_ptr_d   = k_ptr_q + CW'(1);
      k_waddr_d = k_ptr_q[AW-1:0];
      k_wdata_d = k_row;
    end
    if (v_acc) begin
      v_ptr_d   = v_ptr_q + CW'(1);
      v_waddr_d = v_ptr_q[AW-1:0];
      v_wdata_d = v_row;
    end
    if (clear) begin
      k_ptr_d      = '0;
      v_ptr_d      = '0;
      k_cnt_d      = '0;
      v_cnt_d      = '0;
      rows_valid_d = '0;
      k_we_d       = 1'b0;
      v_we_d       = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_ptr_q      <= '0;
      v_ptr_q      <= '0;
      k_cnt_q      <= '0;
      v_cnt_q      <= '0;
      rows_valid_q <= '0;
      k_we_q       <= 1'b0;
      v_we_q       <= 1'b0;
      k_waddr_q    <= '0;
      v_waddr_q    <= '0;
      k_wdata_q    <= '0;
      v_wdata_q    <= '0;
    end else begin
      k_ptr_q      <= k_ptr_d;
      v_ptr_q      <= v_ptr_d;
      k_cnt_q      <= k_cnt_d;
      v_cnt_q      <= v_cnt_d;
      rows_valid_q <= rows_valid_d;
      k_we_q       <= k_we_d;
      v_we_q       <= v_we_d;
      k_waddr_q    <= k_waddr_d;
      v_waddr_q    <= v_waddr_d;
      k_wdata_q    <= k_wdata_d;
      v_wdata_q    <= v_wdata_d;
    end
  end

  // Fill-state next state; kv_done marks only the entry into FULL, never a clear
  always_comb begin
    state_d   = state_q;
    kv_done_d = 1'b0;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (both_full) begin
            state_d = FULL;
          end else if (rows_valid_q != '0) begin
            state_d = FILL;
          end
        end
        FILL: begin
          if (both_full) begin
            state_d = FULL;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
    kv_full_d = (state_d == FULL);
    kv_done_d = (state_d == FULL) && (state_q != FULL);
  end

  // Fill-state register and its registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      kv_full_q <= 1'b0;
      kv_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kv_full_q <= kv_full_d;
      kv_done_q <= kv_done_d;
    end
  end

endmodule

// File: tb/tb_kv_cache_writer.sv
// tb/tb_kv_cache_writer.sv - directed self-checking bench for kv_cache_writer
module tb_kv_cache_writer;

  localparam int M = 4;
  localparam int N = 2;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       freeze;
  logic [3:0] shift;
  logic [2:0] rows_valid;
  logic       kv_full;
  logic       kv_done;

  kv_cache_writer_if #(.M(M), .N(N)) bus ();

  kv_cache_writer #(.M(M), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .freeze     (freeze),
    .shift      (shift),
    .bus        (bus),
    .rows_valid (rows_valid),
    .kv_full    (kv_full),
    .kv_done    (kv_done)
  );

  int n_checks;
  int n_fail;

  int          kw_n;
  int          vw_n;
  int          done_cnt;
  logic [1:0]  kw_addr [64];
  logic [15:0] kw_data [64];
  logic [1:0]  vw_addr [64];
  logic [15:0] vw_data [64];

  logic [15:0] exp_d [4];
  int kb, vb, db;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every presented BRAM write and kv_done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.K_ram_we && kw_n < 64) begin
        kw_addr[kw_n] = bus.K_ram_waddr;
        kw_data[kw_n] = bus.K_ram_wdata;
        kw_n = kw_n + 1;
      end
      if (bus.V_ram_we && vw_n < 64) begin
        vw_addr[vw_n] = bus.V_ram_waddr;
        vw_data[vw_n] = bus.V_ram_wdata;
        vw_n = vw_n + 1;
      end
      if (kv_done) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_k(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.k_in_valid = 1'b1;
      bus.k_in_data  = d;
    end
    @(negedge clk);
    bus.k_in_valid = 1'b0;
  endtask

  task automatic send_v(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.v_in_valid = 1'b1;
      bus.v_in_data  = d;
    end
    @(negedge clk);
    bus.v_in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; kw_n = 0; vw_n = 0; done_cnt = 0;
    rst_n = 1'b0; clear = 1'b0; freeze = 1'b0; shift = 4'd0;
    bus.k_in_valid = 1'b0; bus.k_in_data = '0;
    bus.v_in_valid = 1'b0; bus.v_in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_k_we",    32'(bus.K_ram_we),    32'd0);
    check("rst_k_waddr", 32'(bus.K_ram_waddr), 32'd0);
    check("rst_k_wdata", 32'(bus.K_ram_wdata), 32'd0);
    check("rst_v_we",    32'(bus.V_ram_we),    32'd0);
    check("rst_rows",    32'(rows_valid),      32'd0);
    check("rst_full",    32'(kv_full),         32'd0);
    check("rst_done",    32'(kv_done),         32'd0);
    check("rst_k_ready", 32'(bus.k_in_ready),  32'd1);
    check("rst_v_ready", 32'(bus.v_in_ready),  32'd1);

    // Basic write: four K rows {1,-1}, then four V rows
    kb = kw_n;
    send_k(4, 32'hFFFF_0001);
    #1;
    check("k_ready_at_M", 32'(bus.k_in_ready), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    check("rows_no_v", 32'(rows_valid), 32'd0);
    send_v(4, 32'hFFFF_0001);
    #1;
    check("full_p0", 32'(kv_full), 32'd0);
    @(negedge clk); #1;
    check("full_p1", 32'(kv_full), 32'd0);
    @(negedge clk); #1;
    check("full_p2", 32'(kv_full), 32'd1);
    check("done_p2", 32'(kv_done), 32'd1);
    check("rows_4",  32'(rows_valid), 32'd4);
    @(negedge clk); #1;
    check("done_p3", 32'(kv_done), 32'd0);
    check("done_cnt1", 32'(done_cnt), 32'd1);
    check("full_ready_k", 32'(bus.k_in_ready), 32'd0);
    check("full_ready_v", 32'(bus.v_in_ready), 32'd0);
    check("basic_kw_n", 32'(kw_n - kb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_kaddr%0d", i), 32'(kw_addr[kb+i]), 32'(i));
      check($sformatf("basic_kdata%0d", i), 32'(kw_data[kb+i]), 32'h0000_FF01);
    end

    // Requantisation
    do_clear();
    check("clr_full", 32'(kv_full), 32'd0);
    check("clr_rows", 32'(rows_valid), 32'd0);
    kb = kw_n;
    shift = 4'd4;
    send_k(1, {16'hFFE8, 16'h0018});
    send_k(1, {16'hF060, 16'h0FA0});
    send_k(1, {16'h0008, 16'h0007});
    shift = 4'd0;
    send_k(1, {16'hFFFD, 16'h00C8});
    @(negedge clk); #1;
    exp_d[0] = 16'hFF02; exp_d[1] = 16'h807F; exp_d[2] = 16'h0100; exp_d[3] = 16'hFD7F;
    check("rq_kw_n", 32'(kw_n - kb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rq_addr%0d", i), 32'(kw_addr[kb+i]), 32'(i));
      check($sformatf("rq_data%0d", i), 32'(kw_data[kb+i]), 32'(exp_d[i]));
    end

    // Skewed streams
    do_clear();
    vb = vw_n;
    send_k(3, 32'h0010_0020);
    send_v(1, 32'h0030_0040);
    @(negedge clk); @(negedge clk); #1;
    check("skew_rows1",   32'(rows_valid), 32'd1);
    check("skew_k_ready", 32'(bus.k_in_ready), 32'd1);
    send_k(1, 32'h0010_0020);
    #1;
    check("skew_k_full_ready", 32'(bus.k_in_ready), 32'd0);
    check("skew_v_ready",      32'(bus.v_in_ready), 32'd1);
    send_v(1, 32'h0031_0041);
    @(negedge clk); #1;
    check("skew_vw_n",   32'(vw_n - vb), 32'd2);
    check("skew_vaddr1", 32'(vw_addr[vb+1]), 32'd1);
    check("skew_vdata1", 32'(vw_data[vb+1]), 32'h0000_3141);

    // Freeze with valid held, then resume; freeze again right after the final write
    db = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      freeze = 1'b1;
      bus.v_in_valid = 1'b1;
      bus.v_in_data  = 32'h0050_0060;
      #1;
      check($sformatf("frz_v_ready%0d", i), 32'(bus.v_in_ready), 32'd0);
      check($sformatf("frz_k_ready%0d", i), 32'(bus.k_in_ready), 32'd0);
    end
    check("frz_no_write", 32'(vw_n - vb), 32'd2);
    @(negedge clk);
    freeze = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.v_in_valid = 1'b0;
    freeze = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("frz_full", 32'(kv_full), 32'd1);
    check("frz_done", 32'(kv_done), 32'd1);
    @(negedge clk);
    freeze = 1'b0;
    #1;
    check("frz_vw_n",   32'(vw_n - vb), 32'd4);
    check("frz_vaddr2", 32'(vw_addr[vb+2]), 32'd2);
    check("frz_vaddr3", 32'(vw_addr[vb+3]), 32'd3);
    check("frz_done_cnt", 32'(done_cnt - db), 32'd1);

    // Clear from FULL, then clear in the cycle of a K beat
    db = done_cnt;
    do_clear();
    check("clr2_full",    32'(kv_full), 32'd0);
    check("clr2_k_ready", 32'(bus.k_in_ready), 32'd1);
    send_k(2, 32'h0001_0002);
    bus.k_in_valid = 1'b1;
    clear = 1'b1;
    #1;
    check("clr_beat_ready", 32'(bus.k_in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    bus.k_in_valid = 1'b0;
    #1;
    kb = kw_n;
    @(negedge clk); @(negedge clk); #1;
    check("clr_beat_nowrite", 32'(kw_n - kb), 32'd0);
    check("clr_beat_rows",    32'(rows_valid), 32'd0);
    check("clr_no_done",      32'(done_cnt - db), 32'd0);
    send_k(1, 32'h0001_0002);
    @(negedge clk); #1;
    check("clr_next_addr0", 32'(kw_addr[kw_n-1]), 32'd0);

    // Asynchronous reset in mid-fill
    send_k(2, 32'h0005_0003);
    #1;
    check("prerst_we",    32'(bus.K_ram_we),    32'd1);
    check("prerst_wdata", 32'(bus.K_ram_wdata), 32'h0000_0503);
    rst_n = 1'b0;
    #1;
    check("arst_we",    32'(bus.K_ram_we),    32'd0);
    check("arst_waddr", 32'(bus.K_ram_waddr), 32'd0);
    check("arst_wdata", 32'(bus.K_ram_wdata), 32'd0);
    check("arst_rows",  32'(rows_valid),      32'd0);
    check("arst_full",  32'(kv_full),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_k_ready", 32'(bus.k_in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
